// File: rtl/tm1638_led_ctrl_if.sv
// Pattern-request handshake and TM1638 pin bundle for tm1638_led_ctrl.
// master: pattern source / board side; slave: the controller.
interface tm1638_led_ctrl_if;
  logic [7:0] led_in;
  logic [2:0] brightness;
  logic       start;
  logic       busy;
  logic       done;
  logic       tm_stb;
  logic       tm_clk;
  logic       tm_dio;

  modport master (
    output led_in, brightness, start,
    input  busy, done, tm_stb, tm_clk, tm_dio
  );

  modport slave (
    input  led_in, brightness, start,
    output busy, done, tm_stb, tm_clk, tm_dio
  );
endinterface

// File: rtl/tm1638_led_ctrl.sv
// Write-only TM1638 frame sender: data cmd, address + 16 display bytes, display-control cmd.
// Optional macro TM1638_AUTO_REFRESH_EN: resend automatically when pattern/brightness change.
module tm1638_led_ctrl #(
  parameter int unsigned CLK_DIV = 25
) (
  input logic               clk,
  input logic               rs,
  tm1638_led_ctrl_if.slave  bus
);
  localparam int unsigned DivW = $clog2(2 * CLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] GapLast = DivW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StBitLo, StBitHi, StGap, StDone} state_t;

  state_t          r_state;
  logic [DivW-1:0] r_div;
  logic [2:0]      r_bit;
  logic [4:0]      r_byte;
  logic [1:0]      r_seg;
  logic [7:0]      r_led;
  logic [2:0]      r_bri;
  logic            r_busy, r_done, r_stb, r_clk, r_dio;

  logic            w_trig;
  logic [7:0]      w_cur_byte, w_nxt_byte;
  logic [4:0]      w_last_byte;

  // Segment B byte 0 is the address; then pairs of (blank segments, LED byte).
  function automatic logic [7:0] byte_at(input logic [1:0] seg, input logic [4:0] idx,
                                         input logic [7:0] led, input logic [2:0] bri);
    logic [3:0] li;
    li = idx[4:1] - 4'd1;
    if (seg == 2'd0)      return 8'h40;
    else if (seg == 2'd2) return {5'b10001, bri};
    else if (idx == 5'd0) return 8'hC0;
    else if (idx[0])      return 8'h00;
    else                  return {7'b0, led[li[2:0]]};
  endfunction

  assign w_cur_byte  = byte_at(r_seg, r_byte, r_led, r_bri);
  assign w_nxt_byte  = byte_at(r_seg, r_byte + 5'd1, r_led, r_bri);
  assign w_last_byte = (r_seg == 2'd1) ? 5'd16 : 5'd0;

`ifdef TM1638_AUTO_REFRESH_EN
  logic        r_last_vld;
  logic [10:0] r_last;

  assign w_trig = bus.start || !r_last_vld || ({bus.led_in, bus.brightness} != r_last);

  always_ff @(posedge clk) begin
    if (rs) begin
      r_last_vld <= 1'b0;
      r_last     <= '0;
    end else if (r_state == StIdle && w_trig) begin
      r_last_vld <= 1'b1;
      r_last     <= {bus.led_in, bus.brightness};
    end
  end
`else
  assign w_trig = bus.start;
`endif

  always_ff @(posedge clk) begin
    if (rs) begin
      r_state <= StIdle;
      r_div   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_seg   <= '0;
      r_led   <= '0;
      r_bri   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_stb   <= 1'b1;
      r_clk   <= 1'b1;
      r_dio   <= 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_trig) begin
            r_led   <= bus.led_in;
            r_bri   <= bus.brightness;
            r_busy  <= 1'b1;
            r_stb   <= 1'b0;
            r_div   <= '0;
            r_state <= StSetup;
          end
        end
        StSetup: begin
          if (r_div == DivLast) begin
            r_div   <= '0;
            r_clk   <= 1'b0;
            r_dio   <= w_cur_byte[0];
            r_state <= StBitLo;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        StBitLo: begin
          if (r_div == DivLast) begin
            r_div   <= '0;
            r_clk   <= 1'b1;
            r_state <= StBitHi;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        StBitHi: begin
          if (r_div == DivLast) begin
            r_div <= '0;
            if (r_bit != 3'd7) begin
              r_bit   <= r_bit + 3'd1;
              r_clk   <= 1'b0;
              r_dio   <= w_cur_byte[r_bit + 3'd1];
              r_state <= StBitLo;
            end else if (r_byte != w_last_byte) begin
              r_bit   <= '0;
              r_byte  <= r_byte + 5'd1;
              r_clk   <= 1'b0;
              r_dio   <= w_nxt_byte[0];
              r_state <= StBitLo;
            end else begin
              r_bit   <= '0;
              r_byte  <= '0;
              r_stb   <= 1'b1;
              r_dio   <= 1'b1;
              r_state <= StGap;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        StGap: begin
          if (r_div == GapLast) begin
            r_div <= '0;
            if (r_seg != 2'd2) begin
              r_seg   <= r_seg + 2'd1;
              r_stb   <= 1'b0;
              r_state <= StSetup;
            end else begin
              r_seg   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StDone;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.tm_stb = r_stb;
  assign bus.tm_clk = r_clk;
  assign bus.tm_dio = r_dio;
endmodule
